perf_counter_reader: RTL



---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_snapshot_buf.sv | 29 ++
 rtl/perf_counter_reader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter snapshot reader:
// counter map, entry count and controller state encoding.
package perf_pkg;

    localparam int unsigned PERF_BR_MISS   = 0;
    localparam int unsigned PERF_BR_TOTAL  = 1;
    localparam int unsigned PERF_L1I_MISS  = 2;
    localparam int unsigned PERF_L1I_TOTAL = 3;
    localparam int unsigned PERF_L1D_MISS  = 4;
    localparam int unsigned PERF_L1D_TOTAL = 5;
    localparam int unsigned PERF_L2_MISS   = 6;
    localparam int unsigned PERF_L2_TOTAL  = 7;
    localparam int unsigned PERF_ID_CONF   = 8;

    localparam int unsigned NUM_PERF_CNT = 9;
    localparam logic [3:0]  LAST_IDX     = 4'(NUM_PERF_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_STREAM,
        ST_DONE
    } perf_state_t;

endpackage

// File: rtl/perf_snapshot_buf.sv
// Nine-entry by 32-bit snapshot register file: one synchronous write port,
// one combinational read port (out-of-range reads return zero).
module perf_snapshot_buf
    import perf_pkg::*;
(
    input  logic        clk,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_raddr,
    output logic [31:0] o_rdata
);

    logic [31:0] r_mem [NUM_PERF_CNT];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < 4'(NUM_PERF_CNT))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_raddr < 4'(NUM_PERF_CNT)) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/perf_counter_reader.sv
// Reads the nine performance counters into a snapshot buffer, then streams
// them out over valid/ready; triggered by start or an optional periodic timer.
module perf_counter_reader
    import perf_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 0,
    parameter int unsigned RESP_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        read_b,
    output logic [31:0] address_b,
    input  logic [31:0] rdata_b,
    input  logic        resp_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        overrun
);

    localparam int unsigned TMR_W  = (SAMPLE_PERIOD > 0) ? $clog2(SAMPLE_PERIOD + 1) : 1;
    localparam int unsigned WAIT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

    perf_state_t       r_state;
    logic [3:0]        r_idx;
    logic              r_pending;
    logic [TMR_W-1:0]  r_timer;
    logic [WAIT_W-1:0] r_wait;

    logic        w_fire;
    logic        w_trig;
    logic        w_tmo;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [3:0]  w_raddr;
    logic [31:0] w_rdata;

    assign w_fire  = (SAMPLE_PERIOD != 0) && (r_timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign w_trig  = start || w_fire;
    assign w_tmo   = (r_state == ST_READ) && !resp_b && (r_wait == WAIT_W'(RESP_TIMEOUT - 1));
    assign w_we    = (r_state == ST_READ) && (resp_b || w_tmo);
    assign w_wdata = resp_b ? rdata_b : '1;
    // Read port looks one entry ahead so out_data can be registered on each handshake.
    assign w_raddr = (r_state == ST_STREAM) ? out_index + 4'd1 : '0;

    perf_snapshot_buf u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset || (SAMPLE_PERIOD == 0)) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_fire ? '0 : r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_wait      <= '0;
            read_b      <= 1'b0;
            address_b   <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_trig && (r_state != ST_IDLE)) begin
                if (r_pending) overrun   <= 1'b1;
                else           r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_trig || r_pending) begin
                        r_state   <= ST_READ;
                        r_idx     <= '0;
                        r_wait    <= '0;
                        address_b <= '0;
                        read_b    <= 1'b1;
                        busy      <= 1'b1;
                        // A fresh trigger arriving while a pending one is served stays queued.
                        r_pending <= w_trig && r_pending;
                    end
                end
                ST_READ: begin
                    if (resp_b || w_tmo) begin
                        r_wait <= '0;
                        if (w_tmo) timeout_err <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state   <= ST_STREAM;
                            read_b    <= 1'b0;
                            out_valid <= 1'b1;
                            out_index <= '0;
                            out_data  <= w_rdata;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            address_b <= {28'b0, r_idx + 4'd1};
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (out_index == LAST_IDX) begin
                            r_state   <= ST_DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_index <= out_index + 4'd1;
                            out_data  <= w_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
